// File: rtl/food_map_reader.sv
// Food-map reader: full-map pellet count plus optional single-cell lookup.
// Lookup port is built only when FOOD_MAP_READER_QUERY_EN is defined.
module food_map_reader #(
    parameter int MAP_ROWS = 60,
    parameter int MAP_COLS = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [5:0]  food_addr,
    input  logic [79:0] food_rdata,
    input  logic        scan_start,
    output logic        scan_busy,
    output logic        scan_done,
    output logic [12:0] food_count,
    output logic        level_clear,
    input  logic        query_valid,
    input  logic [6:0]  query_x,
    input  logic [5:0]  query_y,
    output logic        query_ready,
    output logic        resp_valid,
    output logic        resp_food
);

    localparam logic [5:0] LAST_ROW = 6'(MAP_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
`ifdef FOOD_MAP_READER_QUERY_EN
        , QWAIT,
        QRESP
`endif
    } state_t;

    state_t      state_reg;
    logic [5:0]  addr_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [12:0] count_reg;
    logic        clear_reg;
    logic [12:0] acc_reg;
    logic [1:0]  row_pipe_reg;
    logic        drain_reg;
    logic        pend_reg;
    logic        resp_valid_reg;
    logic        resp_food_reg;

    logic [79:0] row_bits;
    logic [12:0] row_count;
    logic        start_req;
    logic        issue_row;

    // Columns at or above MAP_COLS never contribute to the count.
    genvar gi;
    generate
        for (gi = 0; gi < 80; gi++) begin : g_col_mask
            assign row_bits[gi] = (gi < MAP_COLS) ? food_rdata[gi] : 1'b0;
        end
    endgenerate

    always_comb begin
        row_count = '0;
        for (int i = 0; i < 80; i++) begin
            row_count = row_count + 13'(row_bits[i]);
        end
    end

    assign start_req = scan_start || pend_reg;
    // A row address is issued on the acceptance edge and on every SCAN increment.
    assign issue_row = ((state_reg == IDLE) && start_req) ||
                       ((state_reg == SCAN) && (addr_reg != LAST_ROW));

`ifdef FOOD_MAP_READER_QUERY_EN
    localparam logic [6:0] COL_LIMIT = 7'(MAP_COLS);
    localparam logic [5:0] ROW_LIMIT = 6'(MAP_ROWS);

    logic [6:0] qx_reg;
    logic       oor_reg;

    assign query_ready = rst_n && (state_reg == IDLE) && !start_req;
`else
    assign query_ready = 1'b0;
    wire unused_query = &{1'b0, query_valid, query_x, query_y};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            count_reg      <= '0;
            clear_reg      <= 1'b0;
            acc_reg        <= '0;
            row_pipe_reg   <= '0;
            drain_reg      <= 1'b0;
            pend_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_food_reg  <= 1'b0;
`ifdef FOOD_MAP_READER_QUERY_EN
            qx_reg         <= '0;
            oor_reg        <= 1'b0;
`endif
        end else begin
            done_reg       <= 1'b0;
            resp_valid_reg <= 1'b0;
            // Read data for a row lands two edges after its address edge.
            row_pipe_reg   <= {row_pipe_reg[0], issue_row};
            if (row_pipe_reg[1]) begin
                acc_reg <= acc_reg + row_count;
            end

            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        state_reg <= SCAN;
                        busy_reg  <= 1'b1;
                        addr_reg  <= '0;
                        acc_reg   <= '0;
                        pend_reg  <= 1'b0;
                    end
`ifdef FOOD_MAP_READER_QUERY_EN
                    else if (query_valid && query_ready) begin
                        qx_reg    <= query_x;
                        oor_reg   <= (query_x >= COL_LIMIT) || (query_y >= ROW_LIMIT);
                        addr_reg  <= query_y;
                        state_reg <= QWAIT;
                    end
`endif
                end
                SCAN: begin
                    if (addr_reg == LAST_ROW) begin
                        state_reg <= DRAIN;
                        drain_reg <= 1'b0;
                    end else begin
                        addr_reg <= addr_reg + 6'd1;
                    end
                end
                DRAIN: begin
                    if (drain_reg) begin
                        count_reg <= acc_reg;
                        clear_reg <= (acc_reg == 13'd0);
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        drain_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
`ifdef FOOD_MAP_READER_QUERY_EN
                QWAIT: begin
                    if (scan_start) pend_reg <= 1'b1;
                    state_reg <= QRESP;
                end
                QRESP: begin
                    if (scan_start) pend_reg <= 1'b1;
                    resp_valid_reg <= 1'b1;
                    resp_food_reg  <= !oor_reg && food_rdata[qx_reg];
                    state_reg      <= IDLE;
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign food_addr   = addr_reg;
    assign scan_busy   = busy_reg;
    assign scan_done   = done_reg;
    assign food_count  = count_reg;
    assign level_clear = clear_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_food   = resp_food_reg;

endmodule

// File: doc/food_map_reader.md
FOOD_MAP_READER -- requirements
Module: food_map_reader

Interface
REQ-001 SHALL have parameter MAP_ROWS, default 60, number of valid food_map rows (addresses 0..MAP_ROWS-1).
REQ-002 SHALL have parameter MAP_COLS, default 80, number of valid bits per row (bits 0..MAP_COLS-1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port food_addr  output  6  registered read address to food_map.
REQ-006 SHALL have port food_rdata  input  80  food_map read data, valid one clock after the edge that samples food_addr.
REQ-007 SHALL have port scan_start  input  1  request a full-map pellet count.
REQ-008 SHALL have port scan_busy  output  1  high from scan acceptance until the scan_done edge.
REQ-009 SHALL have port scan_done  output  1  one-cycle pulse at scan completion.
REQ-010 SHALL have port food_count  output  13  pellets counted by the last completed scan (max 4800).
REQ-011 SHALL have port level_clear  output  1  high when the last completed scan counted zero pellets.
REQ-012 SHALL have ports query_valid  input  1, query_x  input  7, query_y  input  6  single-cell lookup request.
REQ-013 SHALL have port query_ready  output  1  lookup acceptance; handshake is query_valid & query_ready on a rising edge.
REQ-014 SHALL have ports resp_valid  output  1, resp_food  output  1  lookup result, one-cycle pulse.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DRAIN, DONE, QWAIT, QRESP.
REQ-016 SHALL treat food_map as read-only: the block never drives write enable or write data.
REQ-017 SHALL in IDLE accept scan_start (scan_busy=1, food_addr<=0, accumulator<=0, go to SCAN).
REQ-018 SHALL in SCAN increment food_addr every cycle through MAP_ROWS-1, then go to DRAIN for 2 cycles.
REQ-019 SHALL add popcount(food_rdata[MAP_COLS-1:0]) to a 13-bit accumulator exactly once per row, two edges after that row's address edge; bits at or above MAP_COLS are ignored.
REQ-020 SHALL on the edge MAP_ROWS+2 after acceptance load food_count from the accumulator, set level_clear=(count==0), pulse scan_done for one cycle, drop scan_busy, and return to IDLE via DONE.
REQ-021 SHALL ignore scan_start while scan_busy=1; no restart occurs and no extra scan_done is produced.
REQ-022 SHALL drive query_ready=1 only in IDLE with no scan pending; when scan_start and query_valid are both high in IDLE, the scan wins and query_ready=0.
REQ-023 SHALL on query acceptance register query_x, set food_addr<=query_y, and go to QWAIT; resp_valid SHALL pulse exactly 2 edges after acceptance with resp_food=food_rdata[query_x].
REQ-024 SHALL for out-of-range queries (query_x>=MAP_COLS or query_y>=MAP_ROWS) still respond at the same latency with resp_food=0.
REQ-025 SHALL hold at most one query outstanding; a scan_start arriving while a query is in flight is latched and starts the scan in the cycle after resp_valid.
REQ-026 SHALL hold food_count and level_clear stable between scan_done edges.

Reset
REQ-027 SHALL on rst_n=0 force state IDLE, food_addr=0, scan_busy=0, scan_done=0, food_count=0, level_clear=0, query_ready=0 during reset, resp_valid=0, resp_food=0, and clear any pending scan.
REQ-028 SHALL abandon any in-progress scan or query on reset without a scan_done or resp_valid pulse; the first response after reset release requires a new request.

Configuration
REQ-029 SHALL compile the lookup port only when macro FOOD_MAP_READER_QUERY_EN is defined.
REQ-030 SHALL without FOOD_MAP_READER_QUERY_EN keep the port list unchanged, tie query_ready, resp_valid and resp_food to 0, ignore query inputs, and omit QWAIT/QRESP.

Verification
REQ-031 SHALL cover: map with every bit set in cols 0..79 of rows 0..59, scan_start -> scan_done at edge 62, food_count=4800, level_clear=0.
REQ-032 SHALL cover: all-zero map, scan -> food_count=0, level_clear=1; row 10 = 0x...0005 then rescan -> food_count=2, level_clear=0.
REQ-033 SHALL cover: row 5 bit 17 set, query (x=17,y=5) -> resp_valid 2 edges later, resp_food=1; query (x=80,y=5) -> resp_food=0.
REQ-034 SHALL cover: scan_start and query_valid high together in IDLE -> scan accepted, query_ready=0 until scan_done; scan_start pulsed mid-scan -> single scan_done.
REQ-035 SHALL cover: rst_n=0 at scan edge 30 -> no scan_done, food_count=0, scan_busy=0 on the next cycle; a fresh scan afterwards reports the correct count.
